// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing, types and helpers for the FIFO and its read-side stream adapter
package fifo_pkg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PTR_WIDTH = 4;
  localparam int CNT_WIDTH = 16;
  typedef logic [1:0] skid_cnt_t;
  function automatic logic [2:0] occupancy(input skid_cnt_t count, input logic pend, input logic pop);
    return {1'b0, count} + {2'b0, pend} - {2'b0, pop};
  endfunction
endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: two-entry in-order buffer with push at the tail, pop at the head and synchronous clear
module fifo_skid2 import fifo_pkg::*; #(
  parameter int W = WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         clear,
  output skid_cnt_t    count,
  output logic [W-1:0] head
);
  logic [W-1:0] e0, e1, n0, n1;
  skid_cnt_t wr_idx, n_cnt;
  // next entries: shift on pop, then write the pushed word into the first free slot
  always_comb begin
    wr_idx = count - skid_cnt_t'(pop);
    n0 = (push && wr_idx == 2'd0) ? push_data : pop ? e1 : e0;
    n1 = (push && wr_idx == 2'd1) ? push_data : e1;
    n_cnt = count + skid_cnt_t'(push) - skid_cnt_t'(pop);
  end
  // buffer storage and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      e0 <= '0;
      e1 <= '0;
      count <= '0;
    end else if (clear) begin
      e0 <= '0;
      e1 <= '0;
      count <= '0;
    end else begin
      e0 <= n0;
      e1 <= n1;
      count <= n_cnt;
    end
  end
  assign head = e0;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO read port into a valid/ready stream with prefetch, flush and transfer count
module fifo_rd_stream #(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int CNT_WIDTH = fifo_pkg::CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 fifo_empty_i,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  output logic                 fifo_rd_en_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [WIDTH-1:0]     m_data_o,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] xfer_cnt_o
);
  import fifo_pkg::*;
  skid_cnt_t count;
  logic pend, pop;
  assign m_valid_o = count != 2'd0;
  assign pop = m_valid_o & m_ready_i;
  // read only when the buffer plus the in-flight word leaves a free slot; held low during reset
  assign fifo_rd_en_o = rst_n_i & ~flush_i & ~fifo_empty_i & (occupancy(count, pend, pop) <= 3'd1);
  // pend marks that fifo_rdata_i carries a requested word this cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pend <= 1'b0;
    else pend <= fifo_rd_en_o;
  end
  // completed transfers, including a pop in a flush cycle; never cleared by flush
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) xfer_cnt_o <= '0;
    else xfer_cnt_o <= xfer_cnt_o + CNT_WIDTH'(pop);
  end
  fifo_skid2 #(.W(WIDTH)) u_skid (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (pend & ~flush_i),
    .push_data (fifo_rdata_i),
    .pop       (pop),
    .clear     (flush_i),
    .count     (count),
    .head      (m_data_o)
  );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed vectors and sequences against a behavioural FIFO model
module tb_fifo_rd_stream;
  localparam int NW = 65535 - 215;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic fifo_empty_i, fifo_rd_en_o, m_valid_o;
  logic m_ready_i = 1'b0;
  logic flush_i = 1'b0;
  logic [7:0] fifo_rdata_i = 8'h00;
  logic [7:0] m_data_o;
  logic [15:0] xfer_cnt_o;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] outq[$];
  int fcnt = 0;
  int rd_count = 0;
  logic rd_err = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic wr; logic [7:0] wd; logic rdy; logic fl;
    logic e_rd; logic e_v; logic [7:0] e_d; logic [15:0] e_x;
  } vec_t;
  vec_t tv[16];

  fifo_rd_stream dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .flush_i      (flush_i),
    .xfer_cnt_o   (xfer_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  assign fifo_empty_i = (fcnt == 0);

  // FIFO model (read data one cycle after rd_en) and output scoreboard
  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      rd_count <= rd_count + 1;
      if (fq.size() == 0) rd_err <= 1'b1;
      else fifo_rdata_i <= fq.pop_front();
    end
    if (wr_en) fq.push_back(wr_data);
    fcnt <= fq.size();
    if (m_valid_o && m_ready_i) outq.push_back(m_data_o);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int base, r0, mism, n;
    logic bad;
    logic [7:0] sent[$];
    tv[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
    tv[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
    tv[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
    tv[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 16'd0};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 16'd1};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 16'd2};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 16'd3};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4};
    tv[8]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4};
    tv[9]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd4};
    tv[10] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd4};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 16'd4};
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd4};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4};
    tv[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 16'd4};
    tv[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd5};
    #2;
    chk("reset_outputs", {fifo_rd_en_o, m_valid_o, m_data_o, xfer_cnt_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); #1;
      chk("idle", {fifo_rd_en_o, m_valid_o, m_data_o, xfer_cnt_o}, 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      wr_en = tv[i].wr; wr_data = tv[i].wd; m_ready_i = tv[i].rdy; flush_i = tv[i].fl;
      #1;
      chk($sformatf("vec%0d_rd_en", i), fifo_rd_en_o, tv[i].e_rd);
      chk($sformatf("vec%0d_valid", i), m_valid_o, tv[i].e_v);
      if (tv[i].e_v) chk($sformatf("vec%0d_data", i), m_data_o, tv[i].e_d);
      chk($sformatf("vec%0d_xfer", i), xfer_cnt_o, tv[i].e_x);
    end
    @(negedge clk_i);
    wr_en = 1'b0; m_ready_i = 1'b0; flush_i = 1'b0;
    base = outq.size(); r0 = rd_count; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      wr_en = (i < 10); wr_data = 8'hA0 + 8'(i);
      #1;
      if (m_valid_o && m_data_o !== 8'hA0) bad = 1'b1;
    end
    @(negedge clk_i); wr_en = 1'b0;
    chk("stall_reads", rd_count - r0, 2);
    chk("stall_hold", bad, 1'b0);
    chk("stall_head", {m_valid_o, m_data_o}, {1'b1, 8'hA0});
    m_ready_i = 1'b1;
    for (int i = 0; i < 60 && outq.size() - base < 10; i++) @(negedge clk_i);
    chk("bp_count", outq.size() - base, 10);
    if (outq.size() - base >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("bp_word%0d", i), outq[base + i], 8'hA0 + 8'(i));
    chk("bp_xfer", xfer_cnt_o, 16'd15);
    base = outq.size(); n = 0;
    for (int i = 0; i < 3000 && outq.size() - base < 200; i++) begin
      @(negedge clk_i);
      m_ready_i = 1'($urandom % 2);
      if (n < 200 && ($urandom % 2) == 0) begin
        wr_en = 1'b1; wr_data = 8'($urandom); sent.push_back(wr_data); n++;
      end else wr_en = 1'b0;
    end
    @(negedge clk_i); wr_en = 1'b0; m_ready_i = 1'b1;
    chk("rand_count", outq.size() - base, 200);
    mism = 0;
    for (int i = 0; i < 200 && i < outq.size() - base && i < sent.size(); i++)
      if (outq[base + i] !== sent[i]) mism++;
    chk("rand_order", mism, 0);
    chk("rand_xfer", xfer_cnt_o, 16'd215);
    for (int i = 0; i < NW; i++) begin
      @(negedge clk_i);
      wr_en = 1'b1; wr_data = 8'(i);
      if (i == 1000) begin
        #1;
        chk("steady_rd_en", fifo_rd_en_o, 1'b1);
        chk("steady_valid", m_valid_o, 1'b1);
      end
    end
    @(negedge clk_i); wr_en = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("cnt_max", xfer_cnt_o, 16'hFFFF);
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk_i); wr_en = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("cnt_wrap", xfer_cnt_o, 16'h0000);
    m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
    end
    @(negedge clk_i); wr_en = 1'b0;
    repeat (3) @(negedge clk_i);
    m_ready_i = 1'b1;
    @(negedge clk_i); m_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("pre_rst_xfer", xfer_cnt_o, 16'd1);
    chk("pre_rst_valid", m_valid_o, 1'b1);
    chk("pre_rst_fifo_busy", fifo_empty_i, 1'b0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_rst", {fifo_rd_en_o, m_valid_o, m_data_o, xfer_cnt_o}, 32'd0);
    @(negedge clk_i);
    chk("rst_held_rd_en", fifo_rd_en_o, 1'b0);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("rd_error", rd_err, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
